// File: rtl/dac_controller.sv
// Stereo I2S transmitter for the codec DAC port: a small {left,right} FIFO feeding
// a bit-serial shifter timed off DACLRCK edges, all in the BCLK domain.
//
// state  | meaning
// IDLE   | stopped, DACDAT held low, FIFO still writable
// WAIT   | armed, waiting for the first LRCK fall to start a frame
// SEND_L | shifting the left word (LRCK low)
// SEND_R | shifting the right word (LRCK high)
module dac_controller #(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          i_BCLK,
  input  logic          i_rst_n,
  input  logic          i_play,
  input  logic [31:0]   i_data,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_DACLRCK,
  output logic          o_DACDAT,
  output logic          o_underrun,
  output logic          o_frame_done,
  output logic [LW-1:0] o_level,
  output logic [1:0]    o_PLAY_STATE
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SEND_L = 2'd2,
    SEND_R = 2'd3
  } state_t;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push;
  logic          pop;
  logic          empty;

  state_t      state_q, state_d;
  logic        lrck_prev;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;
  logic        dacdat_q, dacdat_d;
  logic        underrun_q, underrun_d;
  logic        done_q, done_d;
  logic        fall;
  logic        rise;
  logic        start_frame;
  logic [3:0]  bit_idx;

  assign push    = i_valid && o_ready;
  assign empty   = (count == '0);
  assign o_ready = (count != LW'(DEPTH));
  assign o_level = count;

  assign fall    = lrck_prev && !i_DACLRCK;
  assign rise    = !lrck_prev && i_DACLRCK;
  assign bit_idx = 4'd15 - bitcnt_q[3:0];

  assign o_DACDAT     = dacdat_q;
  assign o_underrun   = underrun_q;
  assign o_frame_done = done_q;
  assign o_PLAY_STATE = state_q;

  always_ff @(posedge i_BCLK) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      lrck_prev  <= 1'b0;
      bitcnt_q   <= '0;
      left_q     <= '0;
      right_q    <= '0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lrck_prev  <= i_DACLRCK;
      bitcnt_q   <= bitcnt_d;
      left_q     <= left_d;
      right_q    <= right_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    left_d      = left_q;
    right_d     = right_q;
    dacdat_d    = 1'b0;
    underrun_d  = 1'b0;
    done_d      = 1'b0;
    pop         = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_play) state_d = WAIT;
      end
      WAIT: begin
        if (!i_play)   state_d = IDLE;
        else if (fall) start_frame = 1'b1;
      end
      SEND_L: begin
        if (!i_play) begin
          state_d = IDLE;
        end else if (rise) begin
          dacdat_d = right_q[15];
          bitcnt_d = 5'd1;
          state_d  = SEND_R;
        end else if (!bitcnt_q[4]) begin
          dacdat_d = left_q[bit_idx];
          bitcnt_d = bitcnt_q + 5'd1;
        end
      end
      SEND_R: begin
        if (!i_play) begin
          state_d = IDLE;
        end else if (fall) begin
          start_frame = 1'b1;
        end else if (!bitcnt_q[4]) begin
          dacdat_d = right_q[bit_idx];
          bitcnt_d = bitcnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Occupancy is sampled before this edge's write, so a same-edge write cannot rescue an empty pop.
    if (start_frame) begin
      state_d  = SEND_L;
      bitcnt_d = 5'd1;
      done_d   = 1'b1;
      if (!empty) begin
        pop               = 1'b1;
        {left_d, right_d} = mem[rd_ptr];
      end else begin
        left_d     = '0;
        right_d    = '0;
        underrun_d = 1'b1;
      end
      dacdat_d = left_d[15];
    end
  end

endmodule

// File: tb/tb_dac_controller.sv
// Directed bench for dac_controller: BCLK-paced LRCK frames, DACDAT captured once per
// bit clock and compared against hand-derived sample words.
module tb_dac_controller;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          bclk;
  logic          i_rst_n;
  logic          i_play;
  logic [31:0]   i_data;
  logic          i_valid;
  logic          o_ready;
  logic          i_DACLRCK;
  logic          o_DACDAT;
  logic          o_underrun;
  logic          o_frame_done;
  logic [LW-1:0] o_level;
  logic [1:0]    o_PLAY_STATE;

  dac_controller #(.DEPTH(DEPTH)) dut (
    .i_BCLK      (bclk),
    .i_rst_n     (i_rst_n),
    .i_play      (i_play),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_DACLRCK   (i_DACLRCK),
    .o_DACDAT    (o_DACDAT),
    .o_underrun  (o_underrun),
    .o_frame_done(o_frame_done),
    .o_level     (o_level),
    .o_PLAY_STATE(o_PLAY_STATE)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cap;
  int          n_done;
  int          n_under;
  logic [1:0]  st_first;
  logic [1:0]  st_l;
  logic [1:0]  st_r;
  logic        pend_wr;
  logic [31:0] pend_data;
  logic [31:0] pairs [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // n BCLK periods with LRCK held at lrck; DACDAT of each period shifted into cap
  task automatic cyc(input logic lrck, input int n);
    for (int i = 0; i < n; i++) begin
      i_DACLRCK = lrck;
      if (i == 0 && pend_wr) begin
        i_valid = 1'b1;
        i_data  = pend_data;
        pend_wr = 1'b0;
      end
      @(posedge bclk);
      @(negedge bclk);
      i_valid = 1'b0;
      if (i == 0) st_first = o_PLAY_STATE;
      cap = {cap[30:0], o_DACDAT};
      if (o_frame_done) n_done++;
      if (o_underrun)   n_under++;
    end
  endtask

  task automatic frame(input int half);
    cap     = '0;
    n_done  = 0;
    n_under = 0;
    cyc(1'b0, half);
    st_l = st_first;
    cyc(1'b1, half);
    st_r = st_first;
  endtask

  task automatic write_pair(input logic [31:0] d);
    i_data  = d;
    i_valid = 1'b1;
    @(posedge bclk);
    @(negedge bclk);
    i_valid = 1'b0;
  endtask

  initial begin
    pairs = '{32'hF00D_1234, 32'h8001_7FFE, 32'hC3A5_5A3C, 32'h0F0F_F0F0, 32'hDEAD_BEEF};
    i_rst_n   = 1'b0;
    i_play    = 1'b0;
    i_data    = '0;
    i_valid   = 1'b0;
    i_DACLRCK = 1'b0;
    pend_wr   = 1'b0;
    pend_data = '0;
    cap       = '0;

    @(negedge bclk);
    check("rst_dacdat",   32'(o_DACDAT), 32'd0);
    check("rst_underrun", 32'(o_underrun), 32'd0);
    check("rst_done",     32'(o_frame_done), 32'd0);
    check("rst_level",    32'(o_level), 32'd0);
    check("rst_state",    32'(o_PLAY_STATE), 32'd0);
    check("rst_ready",    32'(o_ready), 32'd1);
    i_rst_n = 1'b1;
    @(negedge bclk);

    // 1: one preloaded pair over a 32-BCLK frame
    write_pair(32'hA5C3_3C5A);
    check("t1_level_pre", 32'(o_level), 32'd1);
    i_play = 1'b1;
    cyc(1'b1, 2);
    check("t1_wait", 32'(o_PLAY_STATE), 32'd1);
    frame(16);
    check("t1_data", cap, 32'hA5C3_3C5A);
    check("t1_done", 32'(n_done), 32'd1);
    check("t1_under", 32'(n_under), 32'd0);
    check("t1_st_l", 32'(st_l), 32'd2);
    check("t1_st_r", 32'(st_r), 32'd3);
    check("t1_level_post", 32'(o_level), 32'd0);

    // 2: empty FIFO for two frames, the second with a write landing on the frame-start edge
    frame(16);
    check("t2a_data", cap, 32'd0);
    check("t2a_under", 32'(n_under), 32'd1);
    check("t2a_done", 32'(n_done), 32'd1);
    check("t2a_st_l", 32'(st_l), 32'd2);
    check("t2a_st_r", 32'(st_r), 32'd3);
    pend_wr   = 1'b1;
    pend_data = 32'h6B2D_94E1;
    frame(16);
    check("t2b_data", cap, 32'd0);
    check("t2b_under", 32'(n_under), 32'd1);
    check("t2b_done", 32'(n_done), 32'd1);
    check("t2b_level", 32'(o_level), 32'd1);
    frame(16);
    check("t2c_data", cap, 32'h6B2D_94E1);
    check("t2c_under", 32'(n_under), 32'd0);
    check("t2c_level", 32'(o_level), 32'd0);

    // 3: overfill the FIFO while idle
    i_play = 1'b0;
    cyc(1'b1, 1);
    check("t3_idle", 32'(o_PLAY_STATE), 32'd0);
    check("t3_dacdat", 32'(o_DACDAT), 32'd0);
    for (int k = 0; k < 5; k++) begin
      i_data  = pairs[k];
      i_valid = 1'b1;
      check($sformatf("t3_ready%0d", k), 32'(o_ready), (k < DEPTH) ? 32'd1 : 32'd0);
      @(posedge bclk);
      @(negedge bclk);
      i_valid = 1'b0;
    end
    check("t3_level", 32'(o_level), 32'd4);

    // 4: stop mid left word, then resume with the next pair
    i_play = 1'b1;
    cyc(1'b1, 2);
    cap = '0;
    cyc(1'b0, 8);
    check("t4_partial", cap, 32'h0000_00F0);
    i_play = 1'b0;
    cyc(1'b0, 1);
    check("t4_idle", 32'(o_PLAY_STATE), 32'd0);
    check("t4_dacdat", 32'(o_DACDAT), 32'd0);
    check("t4_level", 32'(o_level), 32'd3);
    i_play = 1'b1;
    cyc(1'b0, 1);
    cyc(1'b1, 2);
    check("t4_rise_ignored", 32'(o_PLAY_STATE), 32'd1);
    frame(16);
    check("t4_resume", cap, 32'h8001_7FFE);
    check("t4_level_post", 32'(o_level), 32'd2);

    // 5: 8-BCLK LRCK phases truncate each word to its top byte
    frame(8);
    check("t5_data", cap, 32'h0000_C35A);
    check("t5_st_l", 32'(st_l), 32'd2);
    check("t5_st_r", 32'(st_r), 32'd3);
    check("t5_done", 32'(n_done), 32'd1);
    check("t5_level", 32'(o_level), 32'd1);

    // 6: reset in the middle of the right word
    write_pair(32'h1357_9BDF);
    check("t6_level_pre", 32'(o_level), 32'd2);
    cap = '0;
    cyc(1'b0, 16);
    cyc(1'b1, 5);
    check("t6_in_send_r", 32'(o_PLAY_STATE), 32'd3);
    check("t6_level_mid", 32'(o_level), 32'd1);
    i_rst_n = 1'b0;
    i_play  = 1'b0;
    #1;
    check("t6_dacdat", 32'(o_DACDAT), 32'd0);
    check("t6_underrun", 32'(o_underrun), 32'd0);
    check("t6_done", 32'(o_frame_done), 32'd0);
    check("t6_level", 32'(o_level), 32'd0);
    check("t6_state", 32'(o_PLAY_STATE), 32'd0);
    check("t6_ready", 32'(o_ready), 32'd1);
    @(negedge bclk);
    i_rst_n = 1'b1;
    @(negedge bclk);
    write_pair(32'h2468_ACE0);
    i_play = 1'b1;
    cyc(1'b1, 2);
    frame(16);
    check("t6_after_rst", cap, 32'h2468_ACE0);
    check("t6_level_post", 32'(o_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
